vend_txn_sequencer: RTL and testbench

//  Front-end controller for the dual-VM vending datapath. Two customer panels (panel0->VM0, panel1->VM1)

---
 rtl/vend_pkg.sv | 46 ++++
 rtl/rr_arb2.sv | 36 +++
 rtl/vend_txn_sequencer.sv | 147 ++++++++++++++
 tb/tb_vend_txn_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the dual-VM vending front end.
//   status_e     : response status codes returned on resp_status
//   PID_*        : product codes understood by the datapath
//   IDLE_PID_DEF : no-op product code driven while not issuing
//   state_e      : sequencer FSM encoding
//   decode_status: strict-priority flag decode
package vend_pkg;

    typedef enum logic [2:0] {
        ST_OK       = 3'd0,
        ST_INVALID  = 3'd1,
        ST_UNAVAIL  = 3'd2,
        ST_SUGAR    = 3'd3,
        ST_NOTEXACT = 3'd4,
        ST_INSUFF   = 3'd5,
        ST_ERR      = 3'd7
    } status_e;

    localparam logic [2:0] PID_SANDWICH  = 3'd0;
    localparam logic [2:0] PID_CHOCOLATE = 3'd1;
    localparam logic [2:0] PID_WATER     = 3'd2;
    localparam logic [2:0] PID_COFFEE    = 3'd3;
    localparam logic [2:0] PID_TEA       = 3'd4;
    localparam logic [2:0] IDLE_PID_DEF  = 3'b111;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } state_e;

    // flags = {invalid, unavail, sugarUns, notExact, insuff, ready}.
    // The first set bit wins; anything below it is don't-care.
    function automatic status_e decode_status(input logic [5:0] flags);
        status_e st;
        if (flags[5] == 1'b1)      st = ST_INVALID;
        else if (flags[4] == 1'b1) st = ST_UNAVAIL;
        else if (flags[3] == 1'b1) st = ST_SUGAR;
        else if (flags[2] == 1'b1) st = ST_NOTEXACT;
        else if (flags[1] == 1'b1) st = ST_INSUFF;
        else if (flags[0] == 1'b1) st = ST_OK;
        else                       st = ST_ERR;
        return st;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i[1:0]   : request vector
//   accept_i     : grant is taken this cycle; updates the round-robin pointer
//   gnt_o[1:0]   : one-hot combinational grant (zero when no request)
//   gnt_id_o     : index of the granted requester
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_id_o = 1'b0;
        case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_q;  // tie goes to the one not granted last
            default: gnt_id_o = 1'b0;
        endcase
        gnt_o  = (req_i == 2'b00) ? 2'b00 : (gnt_id_o ? 2'b10 : 2'b01);
        last_d = (accept_i && (req_i != 2'b00)) ? gnt_id_o : last_q;
    end

    // Reset to 1 so panel0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/vend_txn_sequencer.sv
// Front-end sequencer for the dual-VM vending datapath.
// Arbitrates two customer panels, issues the granted payload to the datapath
// for exactly one cycle, decodes the returned flags and posts a response.
//   CLK, RST                    : clock, synchronous active-high reset
//   req*/money*/pid*/sugar*     : per-panel request and payload
//   gnt0/gnt1                   : 1-cycle grant pulse
//   resp_*                      : response, qualified by 1-cycle resp_valid
//   dp_money/dp_vm/dp_pid/dp_sugar : to datapath (no-op code outside issue)
//   dp_moneyLeft/dp_itemLeft/dp_flags : from datapath
//   vend_cnt0/vend_cnt1         : saturating OK-vend counters per VM
module vend_txn_sequencer
    import vend_pkg::*;
#(
    parameter logic [2:0]  IDLE_PID = IDLE_PID_DEF,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0,
    input  logic             req1,
    input  logic [5:0]       money0,
    input  logic [5:0]       money1,
    input  logic [2:0]       pid0,
    input  logic [2:0]       pid1,
    input  logic             sugar0,
    input  logic             sugar1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [2:0]       resp_status,
    output logic [5:0]       resp_change,
    output logic [4:0]       resp_items,
    output logic [5:0]       dp_money,
    output logic             dp_vm,
    output logic [2:0]       dp_pid,
    output logic             dp_sugar,
    input  logic [5:0]       dp_moneyLeft,
    input  logic [4:0]       dp_itemLeft,
    input  logic [5:0]       dp_flags,
    output logic [CNT_W-1:0] vend_cnt0,
    output logic [CNT_W-1:0] vend_cnt1
);

    state_e           state_q, state_d;
    logic             accept;
    logic [1:0]       arb_gnt;
    logic             arb_id;
    logic [1:0]       gnt_q;
    logic [5:0]       money_q;
    logic [2:0]       pid_q;
    logic             sugar_q;
    logic             id_q;
    logic             resp_valid_q, resp_id_q;
    logic [2:0]       resp_status_q;
    logic [5:0]       resp_change_q;
    logic [4:0]       resp_items_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    status_e          status;
    logic             issuing;

    rr_arb2 u_arb (
        .clk_i    (CLK),
        .rst_i    (RST),
        .req_i    ({req1, req0}),
        .accept_i (accept),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    accept  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // RST gates the issue so a reset landing in ISSUE never reaches the datapath.
    always_comb begin
        issuing  = (state_q == StIssue) && !RST;
        dp_money = issuing ? money_q : 6'd0;
        dp_vm    = issuing ? id_q : 1'b0;
        dp_pid   = issuing ? pid_q : IDLE_PID;
        dp_sugar = issuing ? sugar_q : 1'b0;
        status   = decode_status(dp_flags);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            gnt_q         <= 2'b00;
            money_q       <= 6'd0;
            pid_q         <= 3'd0;
            sugar_q       <= 1'b0;
            id_q          <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_status_q <= 3'd0;
            resp_change_q <= 6'd0;
            resp_items_q  <= 5'd0;
            cnt0_q        <= '0;
            cnt1_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= accept ? arb_gnt : 2'b00;
            resp_valid_q <= 1'b0;
            if (accept) begin
                money_q <= arb_id ? money1 : money0;
                pid_q   <= arb_id ? pid1 : pid0;
                sugar_q <= arb_id ? sugar1 : sugar0;
                id_q    <= arb_id;
            end
            if (state_q == StCapture) begin
                resp_valid_q  <= 1'b1;
                resp_id_q     <= id_q;
                resp_status_q <= status;
                // Non-OK refunds the latched money, never the datapath's value.
                resp_change_q <= (status == ST_OK) ? dp_moneyLeft : money_q;
                resp_items_q  <= (status == ST_OK) ? dp_itemLeft : 5'd0;
                if (status == ST_OK) begin
                    if (!id_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
                    if (id_q && (cnt1_q != '1))  cnt1_q <= cnt1_q + CNT_W'(1);
                end
            end
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_status = resp_status_q;
    assign resp_change = resp_change_q;
    assign resp_items  = resp_items_q;
    assign vend_cnt0   = cnt0_q;
    assign vend_cnt1   = cnt1_q;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Self-checking bench for vend_txn_sequencer with a behavioural dual-VM datapath.
// Expected responses and grant order are queued when stimulus is driven and
// compared when the DUT pulses gnt/resp_valid.
module tb_vend_txn_sequencer;
    import vend_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0 = 0, req1 = 0, sugar0 = 0, sugar1 = 0;
    logic [5:0] money0 = 0, money1 = 0;
    logic [2:0] pid0 = 0, pid1 = 0;
    logic       gnt0, gnt1, resp_valid, resp_id;
    logic [2:0] resp_status;
    logic [5:0] resp_change;
    logic [4:0] resp_items;
    logic [5:0] dp_money;
    logic       dp_vm;
    logic [2:0] dp_pid;
    logic       dp_sugar;
    logic [5:0] dp_moneyLeft = 0;
    logic [4:0] dp_itemLeft = 0;
    logic [5:0] dp_flags = 0;
    logic [7:0] vend_cnt0, vend_cnt1;

    vend_txn_sequencer #(.IDLE_PID(3'b111), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .money0(money0), .money1(money1),
        .pid0(pid0), .pid1(pid1), .sugar0(sugar0), .sugar1(sugar1),
        .gnt0(gnt0), .gnt1(gnt1),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_status(resp_status),
        .resp_change(resp_change), .resp_items(resp_items),
        .dp_money(dp_money), .dp_vm(dp_vm), .dp_pid(dp_pid), .dp_sugar(dp_sugar),
        .dp_moneyLeft(dp_moneyLeft), .dp_itemLeft(dp_itemLeft), .dp_flags(dp_flags),
        .vend_cnt0(vend_cnt0), .vend_cnt1(vend_cnt1)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic [2:0] st;
        logic [5:0] chg;
        logic [4:0] items;
    } exp_t;
    exp_t exp_q[$];
    bit   gnt_exp_q[$];

    // Datapath model. Mode 0 is the real machine; 1/2/3 force ready/no-flag/notExact.
    int dp_mode = 0;
    int stock0 [5] = '{10, 10, 5, 0, 0};
    int stock1 [5] = '{0, 0, 10, 10, 10};
    function automatic logic [5:0] price(input logic [2:0] p);
        case (p)
            3'd0: return 6'd20;
            3'd1: return 6'd10;
            3'd2: return 6'd5;
            3'd3: return 6'd12;
            default: return 6'd8;
        endcase
    endfunction

    always @(posedge CLK) begin
        int st;
        logic ok;
        ok = dp_vm ? (dp_pid >= 3'd2 && dp_pid <= 3'd4) : (dp_pid <= 3'd2);
        st = ok ? (dp_vm ? stock1[dp_pid] : stock0[dp_pid]) : 0;
        dp_moneyLeft <= 6'd0;
        dp_itemLeft  <= 5'd0;
        if (dp_mode == 1) begin
            dp_flags <= 6'b000001; dp_moneyLeft <= dp_money; dp_itemLeft <= 5'd1;
        end else if (dp_mode == 2) begin
            dp_flags <= 6'b000000;
        end else if (dp_mode == 3) begin
            dp_flags <= 6'b000110;
        end else if (!ok) begin
            dp_flags <= 6'b100011;  // junk lower bits must be ignored
        end else if (st == 0) begin
            dp_flags <= 6'b010001;
        end else if (dp_sugar && dp_pid != PID_COFFEE && dp_pid != PID_TEA) begin
            dp_flags <= 6'b001001;
        end else if (dp_money < price(dp_pid)) begin
            dp_flags <= 6'b000010;
        end else begin
            dp_flags     <= 6'b000001;
            dp_moneyLeft <= dp_money - price(dp_pid);
            dp_itemLeft  <= 5'(st - 1);
            if (dp_vm) stock1[dp_pid] <= st - 1;
            else       stock0[dp_pid] <= st - 1;
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        bit   g;
        if (resp_valid) begin
            resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_id", 32'(resp_id), 32'(e.id));
                check_eq("resp_status", 32'(resp_status), 32'(e.st));
                check_eq("resp_change", 32'(resp_change), 32'(e.chg));
                check_eq("resp_items", 32'(resp_items), 32'(e.items));
            end
        end
        if (gnt0 || gnt1) begin
            check_eq("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            if (gnt_exp_q.size() == 0) begin
                check_eq("unexpected_gnt", 32'({gnt1, gnt0}), 32'd0);
            end else begin
                g = gnt_exp_q.pop_front();
                check_eq("gnt_order", 32'(gnt1), 32'(g));
            end
        end
    end

    task automatic set_panel(input bit p, input logic [5:0] m, input logic [2:0] pid,
                             input logic s, input logic r);
        if (p) begin money1 = m; pid1 = pid; sugar1 = s; req1 = r; end
        else   begin money0 = m; pid0 = pid; sugar0 = s; req0 = r; end
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(posedge CLK); #1;
            if (exp_q.size() == 0 && gnt_exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            check_eq(tag, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            gnt_exp_q.delete();
        end
    endtask

    // One request from one panel; checks gnt at +1 and resp at +3 cycles.
    task automatic do_vend(input bit p, input logic [5:0] m, input logic [2:0] pid,
                           input logic s, input logic [2:0] st, input logic [5:0] chg,
                           input logic [4:0] items);
        int req_cyc, gnt_cyc;
        bit got = 0;
        exp_q.push_back('{id: p, st: st, chg: chg, items: items});
        gnt_exp_q.push_back(p);
        @(posedge CLK); #1;
        set_panel(p, m, pid, s, 1'b1);
        req_cyc = cyc;
        gnt_cyc = cyc;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if ((p && gnt1) || (!p && gnt0)) begin got = 1; gnt_cyc = cyc; end
        end
        set_panel(p, m, pid, s, 1'b0);
        check_eq("gnt_latency", 32'(gnt_cyc - req_cyc), 32'd1);
        wait_drain("resp_timeout");
        check_eq("resp_latency", 32'(resp_cyc - req_cyc), 32'd3);
    endtask

    initial begin
        int ng0, ng1;
        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp", 32'({resp_id, resp_status, resp_change, resp_items}), 32'd0);
        check_eq("rst_dp_pid", 32'(dp_pid), 32'd7);
        check_eq("rst_dp_rest", 32'({dp_money, dp_vm, dp_sugar}), 32'd0);
        check_eq("rst_cnt", 32'({vend_cnt1, vend_cnt0}), 32'd0);
        #1 RST = 1'b0;

        // 1: sandwich on VM0
        do_vend(0, 6'd20, PID_SANDWICH, 0, ST_OK, 6'd0, 5'd9);
        check_eq("t1_cnt0", 32'(vend_cnt0), 32'd1);

        // 2: simultaneous held requests alternate 0,1,0,1 after reset
        pulse_reset();
        check_eq("t2_cnt_clear", 32'({vend_cnt1, vend_cnt0}), 32'd0);
        gnt_exp_q = '{0, 1, 0, 1};
        exp_q.push_back('{id: 0, st: ST_OK, chg: 0, items: 9});
        exp_q.push_back('{id: 1, st: ST_OK, chg: 0, items: 9});
        exp_q.push_back('{id: 0, st: ST_OK, chg: 0, items: 8});
        exp_q.push_back('{id: 1, st: ST_OK, chg: 0, items: 8});
        set_panel(0, 6'd10, PID_CHOCOLATE, 0, 1);
        set_panel(1, 6'd8, PID_TEA, 0, 1);
        ng0 = 0; ng1 = 0;
        for (int i = 0; i < 30 && (req0 || req1); i++) begin
            @(negedge CLK);
            if (gnt0) begin ng0++; if (ng0 == 2) req0 = 0; end
            if (gnt1) begin ng1++; if (ng1 == 2) req1 = 0; end
        end
        req0 = 0; req1 = 0;
        wait_drain("t2_timeout");
        check_eq("t2_cnt0", 32'(vend_cnt0), 32'd2);
        check_eq("t2_cnt1", 32'(vend_cnt1), 32'd2);

        // 3: sugar on water rejected, stock untouched
        do_vend(1, 6'd5, PID_WATER, 1, ST_SUGAR, 6'd5, 5'd0);
        do_vend(1, 6'd5, PID_WATER, 0, ST_OK, 6'd0, 5'd9);
        check_eq("t3_cnt1", 32'(vend_cnt1), 32'd3);

        // 4: invalid product, insufficient money, forced notExact / no-flag
        do_vend(0, 6'd12, PID_COFFEE, 0, ST_INVALID, 6'd12, 5'd0);
        do_vend(1, 6'd10, PID_COFFEE, 0, ST_INSUFF, 6'd10, 5'd0);
        dp_mode = 3;
        do_vend(1, 6'd9, PID_TEA, 0, ST_NOTEXACT, 6'd9, 5'd0);
        dp_mode = 2;
        do_vend(0, 6'd7, PID_SANDWICH, 0, ST_ERR, 6'd7, 5'd0);
        dp_mode = 0;
        check_eq("t4_cnt", 32'({vend_cnt1, vend_cnt0}), 32'({8'd3, 8'd2}));

        // 5: drain VM0 water
        pulse_reset();
        for (int i = 0; i < 5; i++) do_vend(0, 6'd5, PID_WATER, 0, ST_OK, 6'd0, 5'(4 - i));
        do_vend(0, 6'd5, PID_WATER, 0, ST_UNAVAIL, 6'd5, 5'd0);
        check_eq("t5_cnt0", 32'(vend_cnt0), 32'd5);

        // 6: reset landing in ISSUE issues nothing
        gnt_exp_q.push_back(0);
        @(posedge CLK); #1;
        set_panel(0, 6'd10, PID_CHOCOLATE, 0, 1);
        ng0 = 0;
        for (int i = 0; i < 10 && ng0 == 0; i++) begin
            @(negedge CLK);
            if (gnt0) ng0 = 1;
        end
        check_eq("t6_gnt_seen", 32'(ng0), 32'd1);
        RST = 1'b1;
        req0 = 0;
        #1;
        check_eq("t6_dp_pid", 32'(dp_pid), 32'd7);
        check_eq("t6_dp_money", 32'(dp_money), 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check_eq("t6_cnt_clear", 32'({vend_cnt1, vend_cnt0}), 32'd0);
        do_vend(0, 6'd10, PID_CHOCOLATE, 0, ST_OK, 6'd0, 5'd7);
        check_eq("t6_cnt0", 32'(vend_cnt0), 32'd1);

        // Counter saturation
        pulse_reset();
        dp_mode = 1;
        for (int i = 0; i < 257; i++) do_vend(1, 6'd8, PID_TEA, 0, ST_OK, 6'd8, 5'd1);
        dp_mode = 0;
        check_eq("sat_cnt1", 32'(vend_cnt1), 32'd255);
        check_eq("sat_cnt0", 32'(vend_cnt0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
